// File: rtl/cam_pkg.sv
// Shared types and 640x480@60 timing constants for the camera frame-buffer path.
package cam_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned FRAME_PIXELS = VGA_H_ACTIVE * VGA_V_ACTIVE;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned PIX_W = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rd_state_t;

    // Sync/active bundle carried down the read-latency delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } vid_ctl_t;

    localparam vid_ctl_t CTL_BLANK = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// VGA h/v counters with IDLE/RUN frame gating and registered stage-0 sync/active decode.
module vga_timing_gen
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v,
    output logic             o_active0,
    output logic             o_hs0,
    output logic             o_vs0,
    output logic             o_frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

    rd_state_t        state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             active0_q, active0_d;
    logic             hs0_q, hs0_d;
    logic             vs0_q, vs0_d;
    logic             frame_start_q, frame_start_d;
    logic             line_end, frame_end;

    assign line_end  = (h_q == CNT_W'(H_TOTAL - 1));
    assign frame_end = line_end && (v_q == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Frames are never cut short: i_en is only sampled at frame boundaries while running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_en) state_d = RUN;
            RUN:  if (frame_end && !i_en) state_d = IDLE;
        endcase
    end

    always_comb begin
        h_d           = '0;
        v_d           = '0;
        active0_d     = 1'b0;
        hs0_d         = 1'b1;
        vs0_d         = 1'b1;
        frame_start_d = 1'b0;
        if (state_q == RUN) begin
            h_d = line_end ? '0 : h_q + CNT_W'(1);
            v_d = v_q;
            if (line_end) v_d = frame_end ? '0 : v_q + CNT_W'(1);
            active0_d     = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
            hs0_d         = !((h_q >= CNT_W'(HS_FIRST)) && (h_q <= CNT_W'(HS_LAST)));
            vs0_d         = !((v_q >= CNT_W'(VS_FIRST)) && (v_q <= CNT_W'(VS_LAST)));
            frame_start_d = (h_q == '0) && (v_q == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            h_q           <= '0;
            v_q           <= '0;
            active0_q     <= 1'b0;
            hs0_q         <= 1'b1;
            vs0_q         <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            active0_q     <= active0_d;
            hs0_q         <= hs0_d;
            vs0_q         <= vs0_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_h           = h_q;
    assign o_v           = v_q;
    assign o_active0     = active0_q;
    assign o_hs0         = hs0_q;
    assign o_vs0         = vs0_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: rtl/vga_frame_reader.sv
// Scans the frame buffer in raster order and re-aligns BRAM read data with VGA syncs.
module vga_frame_reader
    import cam_pkg::*;
#(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_en,
    input  logic [PIX_W-1:0]  i_rd_data,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic [3:0]        o_red,
    output logic [3:0]        o_green,
    output logic [3:0]        o_blue,
    output logic              o_active,
    output logic              o_frame_start
);

    localparam int unsigned LAST_PIX = H_ACTIVE * V_ACTIVE - 1;
    localparam int unsigned DLY_W    = $bits(vid_ctl_t) * RD_LATENCY;

    logic [CNT_W-1:0] h, v;
    logic             active0, hs0, vs0, frame_start;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_en          (i_en),
        .o_h           (h),
        .o_v           (v),
        .o_active0     (active0),
        .o_hs0         (hs0),
        .o_vs0         (vs0),
        .o_frame_start (frame_start)
    );

    logic [ADDR_W-1:0]                 addr_q, addr_d;
    vid_ctl_t [RD_LATENCY-1:0]         dly_q, dly_d;
    vid_ctl_t                          ctl0, out_q, out_d;
    rgb444_t                           rgb_q, rgb_d;

    // Address is cleared alongside the first pixel decode and steps after each read;
    // it parks on the last pixel through blanking instead of running past the frame.
    always_comb begin
        addr_d = addr_q;
        if ((h == '0) && (v == '0))
            addr_d = '0;
        else if (active0 && (addr_q != ADDR_W'(LAST_PIX)))
            addr_d = addr_q + ADDR_W'(1);
    end

    // Delay line covers the BRAM latency; the output register adds the final stage.
    always_comb begin
        ctl0  = '{hs: hs0, vs: vs0, act: active0};
        dly_d = DLY_W'({dly_q, ctl0});
        out_d = dly_q[RD_LATENCY-1];
        rgb_d = out_d.act ? rgb444_t'(i_rd_data) : '0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            addr_q <= '0;
            dly_q  <= {RD_LATENCY{CTL_BLANK}};
            out_q  <= CTL_BLANK;
            rgb_q  <= '0;
        end else begin
            addr_q <= addr_d;
            dly_q  <= dly_d;
            out_q  <= out_d;
            rgb_q  <= rgb_d;
        end
    end

    assign o_rd_addr     = addr_q;
    assign o_rd_en       = active0;
    assign o_frame_start = frame_start;
    assign o_hsync       = out_q.hs;
    assign o_vsync       = out_q.vs;
    assign o_active      = out_q.act;
    assign o_red         = rgb_q.r;
    assign o_green       = rgb_q.g;
    assign o_blue        = rgb_q.b;

endmodule
